// File: rtl/video_timing_pkg.sv
// Shared video timing constants (1080p defaults) and the line/frame total derivation.
// Downstream pixel stages import this to stay consistent with the generator.
package video_timing_pkg;

  localparam int CNT_W  = 12;
  localparam int FCNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int DEF_WIDTH       = 1920;
  localparam int DEF_HEIGHT      = 1080;
  localparam int DEF_H_SYNC_TIME = 44;
  localparam int DEF_V_SYNC_TIME = 5;
  localparam int DEF_H_F_PORCH   = 88;
  localparam int DEF_V_F_PORCH   = 4;
  localparam int DEF_H_B_PORCH   = 148;
  localparam int DEF_V_B_PORCH   = 36;
  localparam int DEF_H_LR_BORDER = 0;
  localparam int DEF_V_LR_BORDER = 0;
  localparam int DEF_SYNC_POL    = 1;
  localparam int DEF_SYNC_DELAY  = 1;

  // Sync, back porch, border, active, border, front porch.
  function automatic int line_total(input int sync_w, input int b_porch, input int border,
                                    input int active, input int f_porch);
    return sync_w + b_porch + 2 * border + active + f_porch;
  endfunction

  localparam int DEF_H_TOTAL = line_total(DEF_H_SYNC_TIME, DEF_H_B_PORCH, DEF_H_LR_BORDER,
                                          DEF_WIDTH, DEF_H_F_PORCH);
  localparam int DEF_V_TOTAL = line_total(DEF_V_SYNC_TIME, DEF_V_B_PORCH, DEF_V_LR_BORDER,
                                          DEF_HEIGHT, DEF_V_F_PORCH);

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register of STAGES x DATA_W bits; STAGES=0 is a wire.
// Reset flushes every stage to zero (deasserted).
module sync_delay_line #(
  parameter int DATA_W = 1,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  if (STAGES == 0) begin : g_pass
    assign dout = din;
  end else begin : g_sr
    logic [DATA_W-1:0] sr_p1 [STAGES];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < STAGES; i++) sr_p1[i] <= '0;
      end else if (en) begin
        sr_p1[0] <= din;
        for (int i = 1; i < STAGES; i++) sr_p1[i] <= sr_p1[i-1];
      end
    end

    assign dout = sr_p1[STAGES-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters, active-video window, sync pulses,
// line/frame start pulses and a wrapping frame counter.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int H_SYNC_TIME = DEF_H_SYNC_TIME,
  parameter int V_SYNC_TIME = DEF_V_SYNC_TIME,
  parameter int H_F_PORCH   = DEF_H_F_PORCH,
  parameter int V_F_PORCH   = DEF_V_F_PORCH,
  parameter int H_B_PORCH   = DEF_H_B_PORCH,
  parameter int V_B_PORCH   = DEF_V_B_PORCH,
  parameter int H_LR_BORDER = DEF_H_LR_BORDER,
  parameter int V_LR_BORDER = DEF_V_LR_BORDER,
  parameter int SYNC_POL    = DEF_SYNC_POL,
  parameter int SYNC_DELAY  = DEF_SYNC_DELAY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  output logic [CNT_W-1:0]  x,
  output logic [CNT_W-1:0]  y,
  output logic              vde,
  output logic              vde_d,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              line_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = line_total(H_SYNC_TIME, H_B_PORCH, H_LR_BORDER, WIDTH, H_F_PORCH);
  localparam int V_TOTAL = line_total(V_SYNC_TIME, V_B_PORCH, V_LR_BORDER, HEIGHT, V_F_PORCH);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
  end

  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC_TIME);
  localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC_TIME);
  localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC_TIME + H_B_PORCH + H_LR_BORDER);
  localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC_TIME + V_B_PORCH + V_LR_BORDER);
  localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC_TIME + H_B_PORCH + H_LR_BORDER + WIDTH);
  localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC_TIME + V_B_PORCH + V_LR_BORDER + HEIGHT);
  localparam logic             ACT_LVL     = (SYNC_POL != 0);

  // primed is clear after reset: the first enabled cycle lands on (0,0)
  // instead of advancing, so every frame begins with a frame_start pulse.
  logic             primed;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic             frame_wrap;
  logic             hs_raw, vs_raw;

  always_comb begin
    x_nxt      = x;
    y_nxt      = y;
    frame_wrap = 1'b0;
    if (!primed) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (x == H_LAST) begin
      x_nxt = '0;
      if (y == V_LAST) begin
        y_nxt      = '0;
        frame_wrap = 1'b1;
      end else begin
        y_nxt = y + 12'd1;
      end
    end else begin
      x_nxt = x + 12'd1;
    end
  end

  // Stage p0: counters and everything decoded from them share one register.
  always_ff @(posedge clk) begin
    if (rst) begin
      primed      <= 1'b0;
      x           <= '0;
      y           <= '0;
      vde         <= 1'b0;
      hs_raw      <= 1'b0;
      vs_raw      <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      frame_cnt   <= '0;
    end else if (pix_en) begin
      primed      <= 1'b1;
      x           <= x_nxt;
      y           <= y_nxt;
      vde         <= (x_nxt >= H_ACT_START) && (x_nxt < H_ACT_END) &&
                     (y_nxt >= V_ACT_START) && (y_nxt < V_ACT_END);
      hs_raw      <= (x_nxt < H_SYNC_END);
      vs_raw      <= (y_nxt < V_SYNC_END);
      frame_start <= (x_nxt == '0) && (y_nxt == '0);
      line_start  <= (x_nxt == '0);
      if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

  // Stage p1: SYNC_DELAY-deep delay of the active-high raw flags.
  logic [2:0] raw_p0;
  logic [2:0] dly_p1;

  assign raw_p0 = {vde, hs_raw, vs_raw};

  sync_delay_line #(
    .DATA_W (3),
    .STAGES (SYNC_DELAY)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .din  (raw_p0),
    .dout (dly_p1)
  );

  assign vde_d = dly_p1[2];
  assign hsync = ACT_LVL ? dly_p1[1] : ~dly_p1[1];
  assign vsync = ACT_LVL ? dly_p1[0] : ~dly_p1[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small-raster table and sequences, plus
// default-horizontal and default-vertical instances for the 1080p boundaries.
module tb_video_timing_gen;

  localparam int H_T = 16;  // 2+2+2*1+8+2
  localparam int V_T = 12;  // 2+2+2*1+4+2

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small raster instance
  logic        rst, pix_en;
  logic [11:0] x, y;
  logic        vde, vde_d, hsync, vsync, frame_start, line_start;
  logic [15:0] frame_cnt;

  video_timing_gen #(
    .WIDTH(8), .HEIGHT(4), .H_SYNC_TIME(2), .V_SYNC_TIME(2), .H_F_PORCH(2), .V_F_PORCH(2),
    .H_B_PORCH(2), .V_B_PORCH(2), .H_LR_BORDER(1), .V_LR_BORDER(1), .SYNC_POL(1), .SYNC_DELAY(1)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .vde(vde), .vde_d(vde_d),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .line_start(line_start),
    .frame_cnt(frame_cnt)
  );

  // all-default instance
  logic        d_rst, d_en;
  logic [11:0] d_x, d_y;
  logic        d_vde, d_vde_d, d_hsync, d_vsync, d_fs, d_ls;
  logic [15:0] d_fcnt;

  video_timing_gen u_def (
    .clk(clk), .rst(d_rst), .pix_en(d_en), .x(d_x), .y(d_y), .vde(d_vde), .vde_d(d_vde_d),
    .hsync(d_hsync), .vsync(d_vsync), .frame_start(d_fs), .line_start(d_ls), .frame_cnt(d_fcnt)
  );

  // small horizontal, default vertical instance
  logic        t_rst, t_en;
  logic [11:0] t_x, t_y;
  logic        t_vde, t_vde_d, t_hsync, t_vsync, t_fs, t_ls;
  logic [15:0] t_fcnt;

  video_timing_gen #(
    .WIDTH(8), .H_SYNC_TIME(2), .H_F_PORCH(2), .H_B_PORCH(2), .H_LR_BORDER(1)
  ) u_tall (
    .clk(clk), .rst(t_rst), .pix_en(t_en), .x(t_x), .y(t_y), .vde(t_vde), .vde_d(t_vde_d),
    .hsync(t_hsync), .vsync(t_vsync), .frame_start(t_fs), .line_start(t_ls), .frame_cnt(t_fcnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        ls;
    logic        hs;
    logic        vs;
    logic        vde;
  } vec_t;

  vec_t tbl [10];

  // reference model of the small raster
  bit          m_primed;
  int          mx, my, m_fcnt;
  logic        r_hs, r_vs, r_vde, q_hs, q_vs, q_vde, m_fs, m_ls;

  task automatic model_reset();
    m_primed = 0; mx = 0; my = 0; m_fcnt = 0;
    r_hs = 0; r_vs = 0; r_vde = 0; q_hs = 0; q_vs = 0; q_vde = 0; m_fs = 0; m_ls = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; pix_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk); #1;
    m_fs = 0; m_ls = 0;
    if (en) begin
      q_hs = r_hs; q_vs = r_vs; q_vde = r_vde;
      if (!m_primed) begin
        mx = 0; my = 0; m_primed = 1;
      end else if (mx == H_T - 1) begin
        mx = 0;
        if (my == V_T - 1) begin my = 0; m_fcnt = (m_fcnt + 1) % 65536; end
        else my = my + 1;
      end else begin
        mx = mx + 1;
      end
      r_hs  = (mx < 2);
      r_vs  = (my < 2);
      r_vde = (mx >= 5 && mx <= 12 && my >= 5 && my <= 8);
      m_fs  = (mx == 0 && my == 0);
      m_ls  = (mx == 0);
    end
    check("x", 32'(x), 32'(mx));
    check("y", 32'(y), 32'(my));
    check("vde", 32'(vde), 32'(r_vde));
    check("vde_d", 32'(vde_d), 32'(q_vde));
    check("hsync", 32'(hsync), 32'(q_hs));
    check("vsync", 32'(vsync), 32'(q_vs));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("line_start", 32'(line_start), 32'(m_ls));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
  endtask

  initial begin
    int fs_seen, vde_seen, last_fs, clk_i, guard;
    int hs_seen, first_vx, first_vy;
    bit got_vde;

    rst = 1'b1; pix_en = 1'b0;
    d_rst = 1'b1; d_en = 1'b0;
    t_rst = 1'b1; t_en = 1'b0;

    // rst, en, x, y, fs, ls, hs, vs, vde
    tbl[0] = '{1'b1, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 12'd1, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 12'd1, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 12'd2, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 12'd3, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 12'd4, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; pix_en = tbl[i].en;
      @(posedge clk); #1;
      check("tbl_x", 32'(x), 32'(tbl[i].x));
      check("tbl_y", 32'(y), 32'(tbl[i].y));
      check("tbl_frame_start", 32'(frame_start), 32'(tbl[i].fs));
      check("tbl_line_start", 32'(line_start), 32'(tbl[i].ls));
      check("tbl_hsync", 32'(hsync), 32'(tbl[i].hs));
      check("tbl_vsync", 32'(vsync), 32'(tbl[i].vs));
      check("tbl_vde", 32'(vde), 32'(tbl[i].vde));
    end

    // Two full frames with pix_en held high.
    do_reset();
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    fs_seen = 0; vde_seen = 0; last_fs = 0;
    for (int s = 1; s <= 2 * H_T * V_T + 1; s++) begin
      step(1'b1);
      if (vde) vde_seen++;
      if (frame_start) begin
        if (fs_seen > 0) check("frame_period", 32'(s - last_fs), 32'(H_T * V_T));
        fs_seen++; last_fs = s;
      end
    end
    check("frame_start_count", 32'(fs_seen), 32'd3);
    check("vde_cycles_2frames", 32'(vde_seen), 32'd64);
    check("frame_cnt_after_2", 32'(frame_cnt), 32'd2);

    // Run to (7,6) and reset mid-frame.
    guard = 0;
    while (!(mx == 7 && my == 6) && guard < 200) begin step(1'b1); guard++; end
    check("reach_7_6", 32'(mx == 7 && my == 6), 32'd1);
    check("vde_d_before_rst", 32'(vde_d), 32'd1);
    rst = 1'b1; pix_en = 1'b1;
    @(posedge clk); #1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_vde_d", 32'(vde_d), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    model_reset();
    step(1'b1);
    check("restart_frame_start", 32'(frame_start), 32'd1);

    // pix_en toggling every clock: x advances every other clock.
    do_reset();
    fs_seen = 0; last_fs = 0; clk_i = 0;
    while (fs_seen < 3 && clk_i < 1200) begin
      clk_i++;
      step((clk_i % 2) == 1);
      if (frame_start) begin
        if (fs_seen > 0) check("toggle_frame_clocks", 32'(clk_i - last_fs), 32'(2 * H_T * V_T));
        fs_seen++; last_fs = clk_i;
      end
    end
    check("toggle_frames_seen", 32'(fs_seen), 32'd3);

    // Default timing, horizontal: wrap at x=2199 into line 1.
    d_rst = 1'b1; d_en = 1'b1;
    @(posedge clk); #1;
    d_rst = 1'b0;
    hs_seen = 0; vde_seen = 0;
    for (int i = 0; i <= 2200; i++) begin
      @(posedge clk); #1;
      if (d_hsync) hs_seen++;
      if (d_vde) vde_seen++;
      if (i == 2199) begin
        check("def_x_last", 32'(d_x), 32'd2199);
        check("def_y_line0", 32'(d_y), 32'd0);
        check("def_vsync_line0", 32'(d_vsync), 32'd1);
      end
    end
    check("def_x_wrap", 32'(d_x), 32'd0);
    check("def_y_inc", 32'(d_y), 32'd1);
    check("def_line_start", 32'(d_ls), 32'd1);
    check("def_no_frame_start", 32'(d_fs), 32'd0);
    check("def_hsync_width", 32'(hs_seen), 32'd44);
    check("def_vde_in_vsync", 32'(vde_seen), 32'd0);

    // Default timing, vertical: first active line 41, wrap at y=1124.
    t_rst = 1'b1; t_en = 1'b1;
    @(posedge clk); #1;
    t_rst = 1'b0;
    got_vde = 0; first_vx = 0; first_vy = 0;
    for (int i = 0; i <= H_T * 1125; i++) begin
      @(posedge clk); #1;
      if (t_vde && !got_vde) begin got_vde = 1; first_vx = int'(t_x); first_vy = int'(t_y); end
      if (i == H_T * 1125 - 1) begin
        check("tall_x_last", 32'(t_x), 32'd15);
        check("tall_y_last", 32'(t_y), 32'd1124);
        check("tall_fcnt_before", 32'(t_fcnt), 32'd0);
      end
    end
    check("tall_vde_seen", 32'(got_vde), 32'd1);
    check("tall_vde_first_x", 32'(first_vx), 32'd5);
    check("tall_vde_first_y", 32'(first_vy), 32'd41);
    check("tall_x_wrap", 32'(t_x), 32'd0);
    check("tall_y_wrap", 32'(t_y), 32'd0);
    check("tall_frame_start", 32'(t_fs), 32'd1);
    check("tall_frame_cnt", 32'(t_fcnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
